// File: rtl/viterbi_frame_ctrl_if.sv
// viterbi_frame_ctrl_if
//   Groups the controller's datapath-facing signals: the symbol-pair
//   valid/ready handshake toward the branch-metric unit, the path-metric
//   register controls, and the survivor-memory write/traceback-read ports.
//
//   Signals:
//     i_sym_valid  symbol pair presented to the branch-metric unit
//     o_sym_ready  controller accepts a symbol this cycle
//     o_pm_init    one-cycle path-metric initialisation pulse
//     o_pm_en      path-metric register enable
//     o_sm_we      survivor-memory write enable
//     o_sm_waddr   survivor-memory write address (current step index)
//     o_tb_rd      survivor-memory traceback read strobe
//     o_tb_raddr   survivor-memory traceback read address
//
//   Modports:
//     master  the frame controller (drives the o_* signals)
//     slave   the datapath / environment (drives i_sym_valid)
interface viterbi_frame_ctrl_if #(
    parameter int AW = 4
);
    logic          i_sym_valid;
    logic          o_sym_ready;
    logic          o_pm_init;
    logic          o_pm_en;
    logic          o_sm_we;
    logic [AW-1:0] o_sm_waddr;
    logic          o_tb_rd;
    logic [AW-1:0] o_tb_raddr;

    modport master (
        input  i_sym_valid,
        output o_sym_ready,
        output o_pm_init,
        output o_pm_en,
        output o_sm_we,
        output o_sm_waddr,
        output o_tb_rd,
        output o_tb_raddr
    );

    modport slave (
        output i_sym_valid,
        input  o_sym_ready,
        input  o_pm_init,
        input  o_pm_en,
        input  o_sm_we,
        input  o_sm_waddr,
        input  o_tb_rd,
        input  o_tb_raddr
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
//   Frame sequencer for the hard-decision Viterbi decoder. A frame is
//   FRAME_LEN trellis steps: one INIT cycle pulses the path-metric
//   initialisation, ACS accepts FRAME_LEN symbol pairs (bubbles allowed)
//   while writing survivors at the step index, TB sweeps the survivor
//   memory from FRAME_LEN-1 down to 0, and DONE pulses once.
//
//   Ports:
//     i_clk     clock, rising edge
//     i_rst_n   asynchronous active-low reset
//     i_start   begin a frame (honoured only in IDLE)
//     i_abort   synchronous abort back to IDLE from any non-IDLE state
//     sym_bus   handshake / PMU / survivor-memory signals (master side)
//     o_busy    high in every state except IDLE
//     o_done    one-cycle pulse at frame completion
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int AW        = $clog2(FRAME_LEN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic                    i_abort,
    viterbi_frame_ctrl_if.master    sym_bus,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [AW-1:0] LAST_STEP = AW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACS,
        S_TB,
        S_DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] step_q;
    logic [AW-1:0] tb_addr_q;
    logic          accept;
    logic          abort_hit;
    logic          sym_ready;
    logic          pm_init;
    logic          tb_rd;
    logic          busy;
    logic          done;

    // Ready is a pure function of state, so accept never depends on itself.
    assign accept    = sym_bus.i_sym_valid && (state_q == S_ACS);
    assign abort_hit = i_abort && (state_q != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sym_ready = 1'b0;
        pm_init   = 1'b0;
        tb_rd     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (i_start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                pm_init = 1'b1;
                state_d = S_ACS;
            end
            S_ACS: begin
                sym_ready = 1'b1;
                if (accept && (step_q == LAST_STEP)) begin
                    state_d = S_TB;
                end
            end
            S_TB: begin
                tb_rd = 1'b1;
                if (tb_addr_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides the next state only; this cycle's outputs stand.
        if (abort_hit) begin
            state_d = S_IDLE;
        end
    end

    // Step counter saturates at the last step (the FSM leaves ACS on that
    // accept), and the traceback address stops at 0, so neither wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_q    <= '0;
            tb_addr_q <= '0;
        end else if (abort_hit) begin
            step_q    <= '0;
            tb_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        step_q    <= '0;
                        tb_addr_q <= '0;
                    end
                end
                S_ACS: begin
                    if (accept) begin
                        if (step_q == LAST_STEP) begin
                            tb_addr_q <= LAST_STEP;
                        end else begin
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                S_TB: begin
                    if (tb_addr_q != '0) begin
                        tb_addr_q <= tb_addr_q - 1'b1;
                    end
                end
                S_DONE: begin
                    step_q    <= '0;
                    tb_addr_q <= '0;
                end
                default: begin
                    step_q    <= step_q;
                    tb_addr_q <= tb_addr_q;
                end
            endcase
        end
    end

    assign sym_bus.o_sym_ready = sym_ready;
    assign sym_bus.o_pm_init   = pm_init;
    assign sym_bus.o_pm_en     = accept;
    assign sym_bus.o_sm_we     = accept;
    assign sym_bus.o_sm_waddr  = step_q;
    assign sym_bus.o_tb_rd     = tb_rd;
    assign sym_bus.o_tb_raddr  = tb_addr_q;
    assign o_busy              = busy;
    assign o_done              = done;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl
//   Self-checking bench for viterbi_frame_ctrl with FRAME_LEN = 4.
//   Expected survivor write addresses, traceback read addresses and done
//   pulses are queued when a frame is started and popped as the DUT
//   produces them; cycle-exact output vectors are checked against a
//   timing model of the frame.
module tb_viterbi_frame_ctrl;

    localparam int FL = 4;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;

    viterbi_frame_ctrl_if #(.AW(AW)) bus ();

    viterbi_frame_ctrl #(.FRAME_LEN(FL), .AW(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_abort (abort),
        .sym_bus (bus.master),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_exp  = 0;
    int pm_en_cnt = 0;
    logic [AW-1:0] wq[$];
    logic [AW-1:0] rq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < FL; i++) wq.push_back(AW'(i));
        for (int i = FL - 1; i >= 0; i--) rq.push_back(AW'(i));
        done_exp++;
    endtask

    task automatic flush();
        wq.delete();
        rq.delete();
        done_exp = 0;
    endtask

    // {pm_init, sym_ready, pm_en, sm_we, tb_rd, busy, done}
    function automatic logic [6:0] obs();
        return {bus.o_pm_init, bus.o_sym_ready, bus.o_pm_en, bus.o_sm_we,
                bus.o_tb_rd, busy, done};
    endfunction

    // Expected vector c cycles after i_start is presented, continuous valid.
    function automatic logic [6:0] gold(input int c);
        logic [6:0] v;
        v = '0;
        if (c == 1)                           v = 7'b1000010;
        else if (c >= 2 && c <= FL + 1)       v = 7'b0111010;
        else if (c >= FL + 2 && c <= 2*FL+1)  v = 7'b0000110;
        else if (c == 2*FL + 2)               v = 7'b0000011;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.o_pm_en) pm_en_cnt++;
            if (bus.o_sm_we) begin
                check_eq("sm_we_expected", wq.size() > 0, 1);
                if (wq.size() > 0) check_eq("sm_waddr", bus.o_sm_waddr, wq.pop_front());
            end
            if (bus.o_tb_rd) begin
                check_eq("tb_rd_expected", rq.size() > 0, 1);
                if (rq.size() > 0) check_eq("tb_raddr", bus.o_tb_raddr, rq.pop_front());
            end
            if (done) begin
                check_eq("done_expected", done_exp > 0, 1);
                if (done_exp > 0) done_exp--;
            end
        end
    end

    // Called at posedge+1 with the DUT idle.
    task automatic run_frame(input bit busy_starts, input bit abort_with_start, input int rst_cycle);
        for (int c = 0; c <= 2*FL + 3; c++) begin
            start = (c == 0) || (busy_starts && (c == 3 || c == FL + 3));
            abort = (c == 0) && abort_with_start;
            bus.i_sym_valid = 1'b1;
            if (c == 0) push_frame();
            #1;
            check_eq($sformatf("vec_c%0d", c), obs(), gold(c));
            if (c >= 2 && c <= FL + 1) check_eq("waddr_cyc", bus.o_sm_waddr, c - 2);
            if (c >= FL + 2 && c <= 2*FL + 1) check_eq("raddr_cyc", bus.o_tb_raddr, 2*FL + 1 - c);
            if (c == rst_cycle) begin
                #1 rst_n = 1'b0;
                #1;
                check_eq("rst_mid_vec", obs(), 0);
                check_eq("rst_mid_waddr", bus.o_sm_waddr, 0);
                check_eq("rst_mid_raddr", bus.o_tb_raddr, 0);
                flush();
                start = 1'b0;
                abort = 1'b0;
                bus.i_sym_valid = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
                tick();
                break;
            end
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.i_sym_valid = 1'b0;

        // Reset state
        #3;
        check_eq("reset_vec", obs(), 0);
        check_eq("reset_waddr", bus.o_sm_waddr, 0);
        check_eq("reset_raddr", bus.o_tb_raddr, 0);
        #20 rst_n = 1'b1;
        tick();
        bus.i_sym_valid = 1'b1;
        #1;
        check_eq("idle_vec", obs(), 0);
        tick();

        // Abort alone in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check_eq("idle_abort_busy", busy, 0);
        check_eq("idle_abort_ready", bus.o_sym_ready, 0);
        tick();

        // Full frame, then start-while-busy, then abort+start together in IDLE
        run_frame(1'b0, 1'b0, -1);
        run_frame(1'b1, 1'b0, -1);
        run_frame(1'b0, 1'b1, -1);

        // Bubbles
        pm_en_cnt = 0;
        bus.i_sym_valid = 1'b0;
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
        #1;
        check_eq("bub_init", bus.o_pm_init, 1);
        tick();
        for (int k = 0; k < 7; k++) begin
            bus.i_sym_valid = pat[k];
            #1;
            check_eq("bub_pm_en", bus.o_pm_en, pat[k]);
            check_eq("bub_ready", bus.o_sym_ready, 1);
            tick();
        end
        bus.i_sym_valid = 1'b1;
        #1;
        check_eq("bub_tb_ready", bus.o_sym_ready, 0);
        check_eq("bub_tb_rd", bus.o_tb_rd, 1);
        check_eq("bub_tb_raddr", bus.o_tb_raddr, FL - 1);
        bus.i_sym_valid = 1'b0;
        repeat (5) tick();
        check_eq("bub_pm_en_count", pm_en_cnt, 4);

        // Abort at step 2 in ACS
        bus.i_sym_valid = 1'b1;
        start = 1'b1;
        push_frame();
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        #1;
        check_eq("ab_waddr", bus.o_sm_waddr, 2);
        check_eq("ab_pm_en", bus.o_pm_en, 1);
        check_eq("ab_busy", busy, 1);
        tick();
        abort = 1'b0;
        bus.i_sym_valid = 1'b0;
        flush();
        #1;
        check_eq("ab_idle_busy", busy, 0);
        check_eq("ab_idle_ready", bus.o_sym_ready, 0);
        check_eq("ab_idle_waddr", bus.o_sm_waddr, 0);
        repeat (3) tick();
        run_frame(1'b0, 1'b0, -1);

        // Reset during TB at raddr = 1, then a clean frame
        run_frame(1'b0, 1'b0, 2*FL);
        #1;
        check_eq("post_rst_busy", busy, 0);
        tick();
        run_frame(1'b0, 1'b0, -1);

        repeat (2) tick();
        check_eq("wq_drained", wq.size(), 0);
        check_eq("rq_drained", rq.size(), 0);
        check_eq("done_drained", done_exp, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the hard-decision Viterbi decoder. It accepts received symbol pairs over a valid/ready handshake and drives the path-metric register enable and the metric initialisation. It also generates survivor-memory write addresses, then runs a fixed-length traceback read sweep. One frame is FRAME_LEN trellis steps, and the block processes one frame at a time.

Parameters:
FRAME_LEN, 16, trellis steps per frame; legal range 2..256.
AW, $clog2(FRAME_LEN), width of step counter and survivor addresses.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  reset, asynchronous, active-low.
i_start  input  1  single-cycle request to begin a frame; honoured only in IDLE.
i_abort  input  1  synchronous abort; in any non-IDLE state returns the FSM to IDLE on the next edge.
i_sym_valid  input  1  a symbol pair is presented to the branch-metric unit.
o_sym_ready  output  1  controller accepts a symbol this cycle.
o_pm_init  output  1  one-cycle pulse; path-metric registers load initial metrics (state 0 = 0, others = max).
o_pm_en  output  1  path-metric register enable (drives PMU i_en).
o_sm_we  output  1  survivor-memory write enable.
o_sm_waddr  output  AW  survivor-memory write address, equal to the current step index.
o_tb_rd  output  1  survivor-memory read strobe for traceback.
o_tb_raddr  output  AW  traceback read address.
o_busy  output  1  high in every state except IDLE.
o_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values: FSM = IDLE, step counter = 0, traceback address = 0. All outputs are 0, including o_sm_waddr and o_tb_raddr.
- FSM states: IDLE, INIT, ACS, TB, DONE. The state register and counters are reset asynchronously.
- IDLE:
  - o_sym_ready = 0.
  - i_start = 1 -> INIT on the next edge; step counter cleared to 0.
- INIT:
  - Lasts exactly 1 cycle with o_pm_init = 1.
  - -> ACS unconditionally.
- ACS:
  - o_sym_ready = 1 (combinational from state).
  - Accept = i_sym_valid & o_sym_ready.
  - o_pm_en = o_sm_we = accept, combinational in the same cycle, so the PMU and survivor memory capture together with the accepted symbol.
  - o_sm_waddr = step counter (registered). The counter increments on every accept.
  - Cycles with i_sym_valid = 0 are bubbles: no enable, counter held, path metrics hold.
  - Accept while counter = FRAME_LEN-1 -> TB on the next edge. o_sym_ready drops in the cycle after the last accept.
- TB:
  - Traceback address is loaded with FRAME_LEN-1 on entry, so o_tb_raddr = FRAME_LEN-1 in the first TB cycle.
  - o_tb_rd = 1 every TB cycle. The address decrements by 1 per cycle.
  - o_pm_en = 0 and o_sym_ready = 0 throughout TB.
  - The cycle with o_tb_raddr = 0 is the last TB cycle -> DONE.
  - TB lasts exactly FRAME_LEN cycles.
- DONE:
  - o_done = 1 for 1 cycle.
  - -> IDLE. i_start is not sampled in DONE; a start is honoured from the following IDLE cycle.
- Frame timing:
  - Minimum frame with continuous valid: 1 INIT + FRAME_LEN ACS + FRAME_LEN TB + 1 DONE = 2*FRAME_LEN+2 cycles.
  - o_busy rises the cycle after i_start.
- i_start outside IDLE: ignored, with no effect on counters or state.
- i_abort:
  - Priority over every other transition.
  - Same-cycle outputs stay as the current state dictates.
  - Next edge: IDLE, counters cleared, no o_done.
  - i_abort in IDLE has no effect.
  - i_abort and i_start together in IDLE: start is honoured.
- Asynchronous reset mid-frame: all state, counters and outputs return to reset values immediately. The frame in progress is lost and no o_done is produced.
- Counters:
  - Step counter never exceeds FRAME_LEN-1.
  - Traceback address never wraps below 0.
  - With FRAME_LEN a power of two, no modulo wrap is used. The FSM exits before wrap.

Test Plan:
1. Reset:
   - Stimulus: assert i_rst_n = 0 mid-cycle.
   - Required response: all outputs 0 immediately; after release, FSM idle, o_busy = 0, o_sym_ready = 0.
2. Full frame, FRAME_LEN = 4, continuous i_sym_valid:
   - Stimulus: i_start at cycle 0.
   - Required response:
     - o_pm_init at cycle 1.
     - o_pm_en/o_sm_we high cycles 2-5 with waddr 0,1,2,3.
     - o_tb_rd cycles 6-9 with raddr 3,2,1,0.
     - o_done at cycle 10; o_busy high cycles 1-10.
3. Bubbles, FRAME_LEN = 4:
   - Stimulus: i_sym_valid pattern 1,0,0,1,1,0,1.
   - Required response: exactly 4 o_pm_en pulses, waddr 0,1,2,3 only on accepts, TB entered after the 4th accept.
4. Start while busy:
   - Stimulus: pulse i_start during ACS and again during TB.
   - Required response: no effect; a single o_done; frame timing identical to scenario 2.
5. Abort:
   - Stimulus: i_abort while step counter = 2 in ACS.
   - Required response: IDLE next cycle, o_done never pulses, a fresh i_start restarts from waddr 0 with an o_pm_init pulse.
6. Reset during TB:
   - Stimulus: assert i_rst_n at o_tb_raddr = 1.
   - Required response: o_tb_rd and o_busy drop to 0 immediately, no o_done; after release, a new frame runs exactly as in scenario 2.
